// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU: AND/OR/ADD/SLT/NOR in one cycle, shift-add MUL over WIDTH cycles.
// Results and flags are presented through a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// MUL   | shift-add iterations in progress, busy=1
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             binvert,
  input  logic             carryin,
  input  logic [2:0]       operation,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;

  logic [WIDTH-1:0]     bb;
  logic [WIDTH:0]       sum;
  logic                 add_ovf;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_cout;
  logic                 sc_ovf;
  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   acc_next;
  logic                 accept;

  assign accept = start && !busy;

  always_comb begin
    bb      = binvert ? ~b : b;
    sum     = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, carryin};
    add_ovf = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sc_res  = '0;
    sc_cout = 1'b0;
    sc_ovf  = 1'b0;
    case (operation)
      OP_AND: sc_res = a & bb;
      OP_OR:  sc_res = a | bb;
      OP_NOR: sc_res = ~(a | bb);
      OP_ADD: begin
        sc_res  = sum[WIDTH-1:0];
        sc_cout = sum[WIDTH];
        sc_ovf  = add_ovf;
      end
      OP_SLT: begin
        sc_res  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
        sc_cout = sum[WIDTH];
        sc_ovf  = add_ovf;
      end
      default: begin
        sc_res  = '0;
        sc_cout = 1'b0;
        sc_ovf  = 1'b0;
      end
    endcase
  end

  // One multiplier bit per cycle, LSB first; mcand is pre-shifted to the bit's weight
  always_comb begin
    partial  = mplier[0] ? mcand : '0;
    acc_next = acc + partial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (operation == OP_MUL) begin
              state  <= MUL;
              busy   <= 1'b1;
              cnt    <= '0;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
            end else begin
              result   <= sc_res;
              carryout <= sc_cout;
              overflow <= sc_ovf;
              zero     <= (sc_res == '0);
              done     <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == LAST_ITER) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
            result   <= acc_next[WIDTH-1:0];
            carryout <= |acc_next[2*WIDTH-1:WIDTH];
            overflow <= 1'b0;
            zero     <= (acc_next[WIDTH-1:0] == '0);
            done     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32: single-cycle ops, SUB/SLT flags, MUL timing, reset abort.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        binvert;
  logic        carryin;
  logic [2:0]  operation;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carryout;
  logic        overflow;
  logic        zero;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .binvert(binvert), .carryin(carryin), .operation(operation),
    .busy(busy), .done(done), .result(result),
    .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  // obs layout: {result, carryout, overflow, zero, done, busy}
  logic [36:0] obs;
  assign obs = {result, carryout, overflow, zero, done, busy};

  // Presents one request and returns 1ns after the edge that accepts it; start stays high.
  task automatic drive(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bv,
                       input logic bi, input logic ci);
    start = 1'b1; operation = op; a = aa; b = bv; binvert = bi; carryin = ci;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; binvert = 1'b0; carryin = 1'b0; operation = OP_AND;
    #12;
    checks++;
    if (obs !== {32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", obs, {32'h0, 3'b001, 2'b00});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== {32'h0, 3'b001, 2'b00}) begin
      failures++; $display("FAIL reset_idle got=%h exp=%h", obs, {32'h0, 3'b001, 2'b00});
    end
  endtask

  task automatic test_back_to_back();
    drive(OP_AND, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0);
    checks++;
    if (obs !== {32'h00000000, 3'b001, 2'b10}) begin
      failures++; $display("FAIL b2b_and got=%h exp=%h", obs, {32'h00000000, 3'b001, 2'b10});
    end
    drive(OP_OR, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0);
    checks++;
    if (obs !== {32'hFFFFFFFF, 3'b000, 2'b10}) begin
      failures++; $display("FAIL b2b_or got=%h exp=%h", obs, {32'hFFFFFFFF, 3'b000, 2'b10});
    end
    drive(OP_ADD, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0);
    checks++;
    if (obs !== {32'hFFFFFFFF, 3'b000, 2'b10}) begin
      failures++; $display("FAIL b2b_add got=%h exp=%h", obs, {32'hFFFFFFFF, 3'b000, 2'b10});
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== {32'hFFFFFFFF, 3'b000, 2'b00}) begin
      failures++; $display("FAIL b2b_hold got=%h exp=%h", obs, {32'hFFFFFFFF, 3'b000, 2'b00});
    end
  endtask

  task automatic test_sub();
    drive(OP_ADD, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b1);
    start = 1'b0;
    checks++;
    if (obs !== {32'h4B4B4B4B, 3'b110, 2'b10}) begin
      failures++; $display("FAIL sub_flags got=%h exp=%h", obs, {32'h4B4B4B4B, 3'b110, 2'b10});
    end
  endtask

  task automatic test_slt();
    drive(OP_SLT, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1);
    checks++;
    if (obs !== {32'h00000001, 3'b100, 2'b10}) begin
      failures++; $display("FAIL slt_lt got=%h exp=%h", obs, {32'h00000001, 3'b100, 2'b10});
    end
    drive(OP_SLT, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b1);
    start = 1'b0;
    checks++;
    if (obs !== {32'h00000000, 3'b001, 2'b10}) begin
      failures++; $display("FAIL slt_ge got=%h exp=%h", obs, {32'h00000000, 3'b001, 2'b10});
    end
  endtask

  task automatic test_nor_reserved();
    drive(OP_NOR, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b1);
    checks++;
    if (obs !== {32'h5A5A5A5A, 3'b000, 2'b10}) begin
      failures++; $display("FAIL nor_binv got=%h exp=%h", obs, {32'h5A5A5A5A, 3'b000, 2'b10});
    end
    drive(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b1);
    checks++;
    if (obs !== {32'hF000F000, 3'b000, 2'b10}) begin
      failures++; $display("FAIL and_cin_ignored got=%h exp=%h", obs, {32'hF000F000, 3'b000, 2'b10});
    end
    drive(3'b110, 32'h12345678, 32'h1, 1'b0, 1'b1);
    checks++;
    if (obs !== {32'h00000000, 3'b001, 2'b10}) begin
      failures++; $display("FAIL reserved_110 got=%h exp=%h", obs, {32'h00000000, 3'b001, 2'b10});
    end
    drive(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    checks++;
    if (obs !== {32'h80000000, 3'b010, 2'b10}) begin
      failures++; $display("FAIL add_ovf got=%h exp=%h", obs, {32'h80000000, 3'b010, 2'b10});
    end
    drive(3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    start = 1'b0;
    checks++;
    if (obs !== {32'h00000000, 3'b001, 2'b10}) begin
      failures++; $display("FAIL reserved_111 got=%h exp=%h", obs, {32'h00000000, 3'b001, 2'b10});
    end
  endtask

  task automatic test_mul_basic();
    int bad;
    drive(OP_ADD, 32'h1, 32'h2, 1'b0, 1'b0);
    drive(OP_MUL, 32'h7, 32'h6, 1'b1, 1'b1);
    start = 1'b0;
    checks++;
    if (obs !== {32'h3, 3'b000, 2'b01}) begin
      failures++; $display("FAIL mul_accept got=%h exp=%h", obs, {32'h3, 3'b000, 2'b01});
    end
    bad = 0;
    for (int i = 1; i < 32; i++) begin
      if (i == 5) begin
        start = 1'b1; operation = OP_ADD; a = 32'h3; b = 32'h3;
      end else begin
        start = 1'b0; operation = OP_MUL; a = 32'hDEAD; b = 32'hBEEF;
      end
      @(posedge clk); #1;
      if (obs !== {32'h3, 3'b000, 2'b01} && bad == 0) begin
        bad = i;
        $display("FAIL mul_busy cycle=%0d got=%h exp=%h", i, obs, {32'h3, 3'b000, 2'b01});
      end
    end
    checks++;
    if (bad != 0) failures++;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== {32'h0000002A, 3'b000, 2'b10}) begin
      failures++; $display("FAIL mul_7x6 got=%h exp=%h", obs, {32'h0000002A, 3'b000, 2'b10});
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== {32'h0000002A, 3'b000, 2'b00}) begin
      failures++; $display("FAIL mul_done_once got=%h exp=%h", obs, {32'h0000002A, 3'b000, 2'b00});
    end
  endtask

  task automatic test_mul_trunc_then_add();
    drive(OP_MUL, 32'h00010000, 32'h00010000, 1'b0, 1'b0);
    start = 1'b0;
    repeat (31) @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (obs !== {32'h00000000, 3'b101, 2'b10}) begin
      failures++; $display("FAIL mul_trunc got=%h exp=%h", obs, {32'h00000000, 3'b101, 2'b10});
    end
    drive(OP_ADD, 32'h1, 32'h2, 1'b0, 1'b0);
    start = 1'b0;
    checks++;
    if (obs !== {32'h00000003, 3'b000, 2'b10}) begin
      failures++; $display("FAIL add_in_done_cycle got=%h exp=%h", obs, {32'h00000003, 3'b000, 2'b10});
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== {32'h00000003, 3'b000, 2'b00}) begin
      failures++; $display("FAIL add_after_mul_hold got=%h exp=%h", obs, {32'h00000003, 3'b000, 2'b00});
    end
  endtask

  task automatic test_mul_reset_abort();
    int seen;
    drive(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== {32'h0, 3'b001, 2'b00}) begin
      failures++; $display("FAIL reset_abort got=%h exp=%h", obs, {32'h0, 3'b001, 2'b00});
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL abort_no_done got=%0d exp=0", seen);
    end
    drive(OP_ADD, 32'h1, 32'h1, 1'b0, 1'b0);
    start = 1'b0;
    checks++;
    if (obs !== {32'h00000002, 3'b000, 2'b10}) begin
      failures++; $display("FAIL add_after_reset got=%h exp=%h", obs, {32'h00000002, 3'b000, 2'b10});
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_sub();
    test_slt();
    test_nor_reserved();
    test_mul_basic();
    test_mul_trunc_then_add();
    test_mul_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
